// File: rtl/i2c_regfile_if_pkg.sv
// rtl/i2c_regfile_if_pkg.sv - shared FSM state type and slave address for the I2C register file
package i2cregif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [6:0] DEF_SLAVE_ADDR = 7'b1010010;

endpackage

// File: rtl/i2c_regfile_if_evt_sync.sv
// rtl/i2c_regfile_if_evt_sync.sv - 2-flop synchronizer with registered rise/fall pulses
module i2c_evt_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            // Edge pulses are registered so downstream sees a clean one-cycle strobe
            rise_q <= sync_q & ~prev_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/i2c_regfile_if.sv
// rtl/i2c_regfile_if.sv - register file behind an I2C slave core; I2CREGIF_READBACK_EN enables master reads
import i2cregif_pkg::*;

module i2c_regfile_if #(
    parameter int          REGBITS   = 2,
    parameter int          AUTOINC   = 1,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i2c_start,
    input  logic                      i2c_stop,
    input  logic                      i2c_data_vld,
    input  logic                      r_w,
    input  logic [7:0]                data_out,
    output logic [7:0]                data_in,
    output logic [(2**REGBITS)*8-1:0] regFile,
    output logic [REGBITS-1:0]        regAddr,
    output logic                      regDataValid
);

    localparam int NREGS = 2**REGBITS;

    logic [1:0]         rst_pipe;
    logic               rst_int_n;
    logic               start_lvl, start_rise, start_fall;
    logic               stop_lvl, stop_rise, stop_fall;
    logic               vld_lvl, vld_rise, vld_fall;
    logic               rw_lvl, rw_rise, rw_fall;
    logic               rd_req;
    logic               rd_q;
    logic               strobe_q;
    logic [7:0]         byte_q;
    logic [REGBITS-1:0] ptr;
    logic [REGBITS-1:0] ptr_next;
    logic [REGBITS-1:0] reg_addr_q;
    logic [7:0]         regs [NREGS];
    state_t             state;
    logic               evt_unused;

    // Reset asserts immediately but releases in step with clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    i2c_evt_sync u_sync_start (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .async_in (i2c_start),
        .sync_out (start_lvl),
        .rise     (start_rise),
        .fall     (start_fall)
    );

    i2c_evt_sync u_sync_stop (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .async_in (i2c_stop),
        .sync_out (stop_lvl),
        .rise     (stop_rise),
        .fall     (stop_fall)
    );

    i2c_evt_sync u_sync_vld (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .async_in (i2c_data_vld),
        .sync_out (vld_lvl),
        .rise     (vld_rise),
        .fall     (vld_fall)
    );

    i2c_evt_sync u_sync_rw (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .async_in (r_w),
        .sync_out (rw_lvl),
        .rise     (rw_rise),
        .fall     (rw_fall)
    );

`ifdef I2CREGIF_READBACK_EN
    assign rd_req     = rw_lvl;
    assign evt_unused = &{start_rise, stop_rise, stop_fall, vld_rise, rw_rise, rw_fall};
`else
    assign rd_req     = 1'b0;
    assign evt_unused = &{start_rise, stop_rise, stop_fall, vld_rise, rw_rise, rw_fall, rw_lvl};
`endif

    // The byte is held while the synchronized valid is high, so the last sample precedes vld_fall
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            byte_q <= 8'h00;
        end else if (vld_lvl) begin
            byte_q <= data_out;
        end
    end

    assign ptr_next = (AUTOINC != 0) ? ptr + 1'b1 : ptr;

    // A start level (or stop level) holds the FSM in IDLE; the falling start edge launches the transaction
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            ptr        <= '0;
            reg_addr_q <= '0;
            strobe_q   <= 1'b0;
            rd_q       <= 1'b0;
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= RESET_VAL;
            end
        end else begin
            strobe_q <= 1'b0;
            if (start_lvl || stop_lvl) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_fall) begin
                            rd_q  <= rd_req;
                            state <= rd_req ? DATA : PTR;
                        end
                    end
                    PTR: begin
                        if (vld_fall) begin
                            ptr   <= byte_q[REGBITS-1:0];
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (vld_fall) begin
                            if (!rd_q) begin
                                regs[ptr]  <= byte_q;
                                reg_addr_q <= ptr;
                                strobe_q   <= 1'b1;
                            end
                            ptr <= ptr_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef I2CREGIF_READBACK_EN
    logic [7:0] data_in_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            data_in_q <= RESET_VAL;
        end else begin
            data_in_q <= regs[ptr];
        end
    end

    assign data_in = data_in_q;
`else
    assign data_in = 8'h00;
`endif

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_regfile
            assign regFile[8*g +: 8] = regs[g];
        end
    endgenerate

    assign regAddr      = reg_addr_q;
    assign regDataValid = strobe_q;

endmodule
